// File: rtl/spi_frame_sender.sv
// SPI mode-0 frame sender: streams 1..32 bytes from an external frame buffer.
// Define SPI_LSB_FIRST_EN to shift each byte LSB first (default MSB first).
module spi_frame_sender #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] count,
    output logic [4:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic       spi_clock,
    output logic       spi_data,
    output logic       cs_n,
    output logic       busy,
    output logic       done_send
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_div;
    logic [2:0]  r_bit;
    logic [7:0]  r_sh;
    logic [5:0]  r_len;
    logic [4:0]  r_addr;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_div_nxt;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  w_sh_nxt;
    logic [5:0]  w_len_nxt;
    logic [4:0]  w_addr_nxt;
    logic        w_sclk_nxt;
    logic        w_mosi_nxt;
    logic        w_cs_n_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    logic        w_phase_end;
    logic        w_byte_end;
    logic        w_more;
    logic [5:0]  w_len_in;
    logic        w_first;
    logic        w_next_bit;
    logic [7:0]  w_sh_shift;

    assign w_phase_end = (r_div == DIV_LAST);
    assign w_byte_end  = (r_state == S_SHIFT) && w_phase_end
                         && r_sclk && (r_bit == 3'd7);
    assign w_more      = ({1'b0, r_addr} + 6'd1) < r_len;
    assign w_len_in    = (count > 6'd32) ? 6'd32 : count;

`ifdef SPI_LSB_FIRST_EN
    assign w_first    = mem_data[0];
    assign w_next_bit = r_sh[1];
    assign w_sh_shift = {1'b0, r_sh[7:1]};
`else
    assign w_first    = mem_data[7];
    assign w_next_bit = r_sh[6];
    assign w_sh_shift = {r_sh[6:0], 1'b0};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && (count != 6'd0)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_byte_end) begin
                    w_state_nxt = w_more ? S_FETCH : S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_div_nxt  = r_div;
        w_bit_nxt  = r_bit;
        w_sh_nxt   = r_sh;
        w_len_nxt  = r_len;
        w_addr_nxt = r_addr;
        w_sclk_nxt = r_sclk;
        w_mosi_nxt = r_mosi;
        w_cs_n_nxt = r_cs_n;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (count == 6'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_len_nxt  = w_len_in;
                        w_addr_nxt = 5'd0;
                        w_busy_nxt = 1'b1;
                        w_div_nxt  = 8'd0;
                        w_bit_nxt  = 3'd0;
                    end
                end
            end
            S_FETCH: begin
                w_div_nxt = 8'd0;
            end
            S_LOAD: begin
                w_sh_nxt   = mem_data;
                w_mosi_nxt = w_first;
                w_cs_n_nxt = 1'b0;
                w_div_nxt  = 8'd0;
                w_bit_nxt  = 3'd0;
            end
            S_SHIFT: begin
                if (w_phase_end) begin
                    w_div_nxt  = 8'd0;
                    w_sclk_nxt = ~r_sclk;
                    // Falling edge: advance to the next bit or finish the byte
                    if (r_sclk) begin
                        if (r_bit == 3'd7) begin
                            if (w_more) begin
                                w_addr_nxt = r_addr + 5'd1;
                            end
                        end else begin
                            w_bit_nxt  = r_bit + 3'd1;
                            w_sh_nxt   = w_sh_shift;
                            w_mosi_nxt = w_next_bit;
                        end
                    end
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    w_div_nxt  = 8'd0;
                    w_cs_n_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            default: begin
                w_div_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= 8'd0;
            r_bit  <= 3'd0;
            r_sh   <= 8'd0;
            r_len  <= 6'd0;
            r_addr <= 5'd0;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_cs_n <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_bit  <= w_bit_nxt;
            r_sh   <= w_sh_nxt;
            r_len  <= w_len_nxt;
            r_addr <= w_addr_nxt;
            r_sclk <= w_sclk_nxt;
            r_mosi <= w_mosi_nxt;
            r_cs_n <= w_cs_n_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign mem_addr  = r_addr;
    assign spi_clock = r_sclk;
    assign spi_data  = r_mosi;
    assign cs_n      = r_cs_n;
    assign busy      = r_busy;
    assign done_send = r_done;

endmodule
